// File: rtl/uart_spram_loader.sv
// UART 8N1 receiver feeding a length-prefixed SPRAM write sequencer (host-supplied image load).
// Latency: stop-bit sample -> byte_valid next clock -> mem_write the clock after (2 clocks).
// Backpressure: none; the SPRAM accepts one write per clock and bytes arrive >= 10 bit-times apart.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx              asynchronous serial input, idle high
//   mem_addr/mem_write/mem_data_in   SPRAM write port (byte address, 1-cycle strobe, byte)
//   busy            load in progress (first length byte seen, not yet done/error)
//   done            level, all payload bytes written; held until rst
//   frame_err       sticky, a stop bit was sampled low; held until rst
module uart_spram_loader #(
   parameter int          CLK_FREQ  = 12_000_000,
   parameter int          BAUD      = 9600,
   parameter logic [14:0] BASE_ADDR = 15'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [14:0] mem_addr,
   output logic        mem_write,
   output logic [7:0]  mem_data_in,
   output logic        busy,
   output logic        done,
   output logic        frame_err
);

   // CLK_FREQ/BAUD must be at least 4 for the half-bit start check to be meaningful.
   localparam int            CPB     = CLK_FREQ / BAUD;
   localparam int            CW      = $clog2(CPB + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t;
   typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

   rx_state_t     rx_state, rx_next;
   ld_state_t     ld_state, ld_next;
   logic          rx_m, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_valid, frame_pulse;
   logic          tick;
   logic [14:0]   len, idx;
   logic          wr_en, last_byte, len_zero;

   // ---------------- receiver ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state    <= RX_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         byte_valid  <= 1'b0;
         frame_pulse <= 1'b0;
      end else begin
         rx_state    <= rx_next;
         byte_valid  <= (rx_state == RX_STOP) && tick && rx_s;
         frame_pulse <= (rx_state == RX_STOP) && tick && !rx_s;
         // Counter measures time inside START/DATA/STOP and restarts on every sample point.
         if (tick || rx_state == RX_IDLE || rx_state == RX_RECOVER)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (rx_state == RX_IDLE)
            bit_idx <= '0;
         if (rx_state == RX_DATA && tick) begin
            shreg   <= {rx_s, shreg[7:1]};   // LSB arrives first
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:    if (!rx_s) rx_next = RX_START;
         RX_START:   if (tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:    if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:    if (tick) rx_next = rx_s ? RX_IDLE : RX_RECOVER;
         RX_RECOVER: if (rx_s) rx_next = RX_IDLE;
         default:    rx_next = RX_IDLE;
      endcase
   end

   // Sample point: mid start bit in START, one full bit later in DATA/STOP.
   always_comb begin
      tick = 1'b0;
      case (rx_state)
         RX_START:         tick = (cnt == HALF_M1);
         RX_DATA, RX_STOP: tick = (cnt == FULL_M1);
         default:          tick = 1'b0;
      endcase
   end

   // ---------------- loader ----------------
   // shreg stays stable while byte_valid is high (next frame's data bits are far away).
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state    <= LD_LEN_LO;
         len         <= '0;
         idx         <= '0;
         mem_addr    <= BASE_ADDR;
         mem_write   <= 1'b0;
         mem_data_in <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         ld_state  <= ld_next;
         mem_write <= wr_en;
         if (frame_pulse)
            frame_err <= 1'b1;
         if (ld_state == LD_LEN_LO && byte_valid) begin
            len[7:0] <= shreg;
            busy     <= 1'b1;
         end
         if (ld_state == LD_LEN_HI && byte_valid) begin
            len[14:8] <= shreg[6:0];
            idx       <= '0;
         end
         if (wr_en) begin
            mem_addr    <= BASE_ADDR + idx;   // wraps modulo 2^15
            mem_data_in <= shreg;
            idx         <= idx + 15'd1;
         end
         if (ld_next != ld_state && (ld_next == LD_DONE || ld_next == LD_ERR))
            busy <= 1'b0;
         if (ld_next == LD_DONE && ld_state != LD_DONE)
            done <= 1'b1;
      end
   end

   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LD_LEN_LO: begin
            if (frame_pulse)     ld_next = LD_ERR;
            else if (byte_valid) ld_next = LD_LEN_HI;
         end
         LD_LEN_HI: begin
            if (frame_pulse)     ld_next = LD_ERR;
            else if (byte_valid) ld_next = len_zero ? LD_DONE : LD_DATA;
         end
         LD_DATA: begin
            if (frame_pulse)                   ld_next = LD_ERR;
            else if (byte_valid && last_byte)  ld_next = LD_DONE;
         end
         default: ld_next = ld_state;   // DONE and ERR hold until rst
      endcase
   end

   always_comb begin
      wr_en     = (ld_state == LD_DATA) && byte_valid;
      last_byte = (idx == len - 15'd1);
      len_zero  = ({shreg[6:0], len[7:0]} == 15'd0);
   end

endmodule

// File: tb/tb_uart_spram_loader.sv
module tb_uart_spram_loader;

   localparam int CF  = 160;
   localparam int BD  = 10;
   localparam int CPB = 16;
   localparam logic [14:0] BASE_A = 15'h0000;
   localparam logic [14:0] BASE_B = 15'h7FFE;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [14:0] a0, a1;
   logic [7:0]  d0, d1;
   logic        w0, w1, bz0, bz1, dn0, dn1, fe0, fe1;

   always #5 clk = ~clk;

   // Two instances share the serial line; one at base 0, one near the top of the address space.
   uart_spram_loader #(.CLK_FREQ(CF), .BAUD(BD), .BASE_ADDR(BASE_A)) dut0 (
      .clk(clk), .rst(rst), .rx(rx), .mem_addr(a0), .mem_write(w0), .mem_data_in(d0),
      .busy(bz0), .done(dn0), .frame_err(fe0));
   uart_spram_loader #(.CLK_FREQ(CF), .BAUD(BD), .BASE_ADDR(BASE_B)) dut1 (
      .clk(clk), .rst(rst), .rx(rx), .mem_addr(a1), .mem_write(w1), .mem_data_in(d1),
      .busy(bz1), .done(dn1), .frame_err(fe1));

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed writes: {addr, data, done-at-write}
   logic [23:0] obs0[$], obs1[$];
   logic        pw0 = 1'b0, pw1 = 1'b0;

   always @(negedge clk) begin
      if (w0) begin
         check("no_b2b_0", {31'd0, pw0}, 32'd0);
         obs0.push_back({a0, d0, dn0});
      end
      if (w1) begin
         check("no_b2b_1", {31'd0, pw1}, 32'd0);
         obs1.push_back({a1, d1, dn1});
      end
      pw0 = w0;
      pw1 = w1;
   end

   // Stream since last reset: {stop_ok, byte}
   logic [8:0]  sent[$];
   logic [23:0] exp_w[$];
   logic        m_done, m_busy, m_fe;

   // Reference: first two good bytes form a 15-bit length, then that many bytes land at
   // base+0, base+1, ...; a bad stop bit before completion freezes the load.
   task automatic model(input logic [14:0] base);
      int          n;
      logic        err;
      logic [14:0] ln;
      logic [7:0]  lo, b;
      logic [14:0] ad;
      logic        last;
      n = 0; err = 0; ln = 0; lo = 0;
      exp_w.delete();
      m_done = 0; m_fe = 0;
      foreach (sent[i]) begin
         b = sent[i][7:0];
         if (!sent[i][8]) begin
            m_fe = 1;
            if (!m_done) err = 1;
         end else if (!m_done && !err) begin
            if (n == 0) lo = b;
            else if (n == 1) begin
               ln = {b[6:0], lo};
               if (ln == 0) m_done = 1;
            end else begin
               ad   = base + 15'(n - 2);
               last = ((n - 2) == int'(ln) - 1);
               exp_w.push_back({ad, b, last});
               if (last) m_done = 1;
            end
            n++;
         end
      end
      m_busy = (n >= 1) && !m_done && !err;
   endtask

   task automatic compare_all(input string tag);
      model(BASE_A);
      check({tag, "_nwr0"}, obs0.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < obs0.size(); i++)
         check({tag, "_wr0"}, {8'd0, obs0[i]}, {8'd0, exp_w[i]});
      check({tag, "_done0"}, {31'd0, dn0}, {31'd0, m_done});
      check({tag, "_busy0"}, {31'd0, bz0}, {31'd0, m_busy});
      check({tag, "_fe0"},   {31'd0, fe0}, {31'd0, m_fe});
      model(BASE_B);
      check({tag, "_nwr1"}, obs1.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < obs1.size(); i++)
         check({tag, "_wr1"}, {8'd0, obs1[i]}, {8'd0, exp_w[i]});
      check({tag, "_done1"}, {31'd0, dn1}, {31'd0, m_done});
      check({tag, "_busy1"}, {31'd0, bz1}, {31'd0, m_busy});
      check({tag, "_fe1"},   {31'd0, fe1}, {31'd0, m_fe});
   endtask

   task automatic send(input logic [7:0] b, input logic ok);
      sent.push_back({ok, b});
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4 + $urandom_range(0, 12)) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sent.delete();
      obs0.delete();
      obs1.delete();
   endtask

   initial begin
      int          ln, errpos;
      logic [7:0]  hi;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_addr0", {17'd0, a0}, {17'd0, BASE_A});
      check("rst_addr1", {17'd0, a1}, {17'd0, BASE_B});
      check("rst_out0", {26'd0, w0, d0 == 8'd0, bz0, dn0, fe0, 1'b0}, {26'd0, 1'b0, 1'b1, 4'd0});
      check("rst_out1", {26'd0, w1, d1 == 8'd0, bz1, dn1, fe1, 1'b0}, {26'd0, 1'b0, 1'b1, 4'd0});
      rst = 1'b0;
      obs0.delete(); obs1.delete();

      // basic load
      send(8'h04, 1); send(8'h00, 1); send(8'h41, 1);
      compare_all("basic_mid");
      send(8'h42, 1); send(8'h43, 1); send(8'h44, 1);
      compare_all("basic");

      // zero length then a trailing byte
      do_reset();
      send(8'h00, 1); send(8'h00, 1);
      compare_all("zero");
      send(8'h55, 1);
      compare_all("zero_trail");

      // length high byte bit 7 ignored; instance B wraps past 0x7FFF
      do_reset();
      send(8'h03, 1); send(8'h80, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
      compare_all("wrap");

      // glitch while idle, then a framing error in the length phase
      do_reset();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      compare_all("glitch");
      send(8'hA5, 0);
      compare_all("ferr");
      send(8'h02, 1); send(8'h00, 1); send(8'hAA, 1); send(8'hBB, 1);
      compare_all("ferr_after");

      // reset in the middle of a load
      do_reset();
      send(8'h08, 1); send(8'h00, 1); send(8'hD1, 1); send(8'hD2, 1); send(8'hD3, 1);
      compare_all("midload");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sent.delete(); obs0.delete(); obs1.delete();
      send(8'h01, 1); send(8'h00, 1); send(8'h7E, 1);
      compare_all("after_rst");

      // randomized loads, some with a framing error somewhere in the stream
      for (int it = 0; it < 4; it++) begin
         do_reset();
         ln     = $urandom_range(1, 5);
         hi     = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
         errpos = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, ln + 2)) : -1;
         for (int k = 0; k < ln + 3; k++) begin
            logic [7:0] b;
            if (k == 0)      b = 8'(ln);
            else if (k == 1) b = hi;
            else             b = 8'($urandom_range(0, 255));
            send(b, (k != errpos));
         end
         compare_all("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
